// File: rtl/afifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its read-side stream adapter.
package afifo_pkg;

    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } rd_occ_e;

endpackage

// File: rtl/afifo_rd_skid.sv
// Two-entry skid buffer: head drives the output stream, tail absorbs the word
// that was already popped when downstream stalled.
module afifo_rd_skid
    import afifo_pkg::*;
#(
    parameter int DATASIZE = afifo_pkg::DATASIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [DATASIZE-1:0] din,
    input  logic                m_ready,
    output logic                full,
    output logic                m_valid,
    output logic [DATASIZE-1:0] m_data
);

    rd_occ_e             state;
    logic [DATASIZE-1:0] head;
    logic [DATASIZE-1:0] tail;
    logic                pop;

    assign pop    = m_valid & m_ready;
    assign full   = (state == TWO);
    assign m_data = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            head    <= '0;
            tail    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state   <= ONE;
                        m_valid <= 1'b1;
                        head    <= din;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state <= TWO;
                        tail  <= din;
                    end else if (pop && !push) begin
                        state   <= EMPTY;
                        m_valid <= 1'b0;
                    end else if (push && pop) begin
                        head <= din;
                    end
                end
                TWO: begin
                    // push is blocked upstream while full, so only a pop can move us
                    if (pop) begin
                        state <= ONE;
                        head  <= tail;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/afifo_rd_stream.sv
// Read-side consumer: pops the FIFO into a skid buffer and presents a registered
// valid/ready stream, counting completed handshakes.
module afifo_rd_stream
    import afifo_pkg::*;
#(
    parameter int DATASIZE = afifo_pkg::DATASIZE,
    parameter int CNTSIZE  = 16
) (
    input  logic                rclk,
    input  logic                r_rst,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    input  logic                en,
    output logic                m_valid,
    output logic [DATASIZE-1:0] m_data,
    input  logic                m_ready,
    output logic [CNTSIZE-1:0]  word_cnt
);

    logic full;

    // Gating on full (a registered state) keeps m_ready out of the rinc path.
    assign rinc = en & ~rempty & ~full & ~r_rst;

    afifo_rd_skid #(
        .DATASIZE(DATASIZE)
    ) u_skid (
        .clk    (rclk),
        .rst    (r_rst),
        .push   (rinc),
        .din    (rdata),
        .m_ready(m_ready),
        .full   (full),
        .m_valid(m_valid),
        .m_data (m_data)
    );

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            word_cnt <= '0;
        end else if (m_valid && m_ready) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: queue-based FIFO and buffer model, directed scenarios
// followed by randomized traffic with occasional asynchronous resets.
module tb_afifo_rd_stream;

    logic       rclk = 1'b0;
    logic       r_rst;
    logic       rempty;
    logic [7:0] rdata;
    logic       en;
    logic       m_ready;

    logic        rinc, m_valid;
    logic [7:0]  m_data;
    logic [15:0] word_cnt;
    logic        rinc_w, m_valid_w;
    logic [7:0]  m_data_w;
    logic [3:0]  word_cnt_w;

    afifo_rd_stream #(.DATASIZE(8), .CNTSIZE(16)) dut (
        .rclk(rclk), .r_rst(r_rst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .en(en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .word_cnt(word_cnt)
    );

    afifo_rd_stream #(.DATASIZE(8), .CNTSIZE(4)) dut_w (
        .rclk(rclk), .r_rst(r_rst), .rempty(rempty), .rdata(rdata), .rinc(rinc_w),
        .en(en), .m_valid(m_valid_w), .m_data(m_data_w), .m_ready(m_ready),
        .word_cnt(word_cnt_w)
    );

    always #5 rclk = ~rclk;

    logic [7:0] fifo_q[$];
    logic [7:0] buf_q[$];
    logic [7:0] log_q[$];
    int         log_cyc[$];
    int         cnt = 0;
    int         cyc = 0;
    int         rinc_pulses = 0;
    int         first_rinc_cyc = -1;
    int         pass_n = 0;
    int         total_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else
            pass_n++;
    endtask

    // One clock cycle: present FIFO head, check outputs, then advance the model on the edge.
    task automatic step();
        logic exp_rinc, pop;
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'($urandom) : fifo_q[0];
        #1;
        exp_rinc = en && (fifo_q.size() > 0) && (buf_q.size() < 2) && !r_rst;
        pop      = (buf_q.size() > 0) && m_ready && !r_rst;
        chk("rinc", rinc, exp_rinc);
        chk("m_valid", m_valid, buf_q.size() > 0);
        if (buf_q.size() > 0) chk("m_data", m_data, buf_q[0]);
        chk("word_cnt", word_cnt, cnt % 65536);
        chk("rinc_w", rinc_w, exp_rinc);
        chk("m_valid_w", m_valid_w, buf_q.size() > 0);
        if (buf_q.size() > 0) chk("m_data_w", m_data_w, buf_q[0]);
        chk("word_cnt_w", word_cnt_w, cnt % 16);
        if (exp_rinc && first_rinc_cyc < 0) first_rinc_cyc = cyc;
        @(posedge rclk);
        if (pop) begin
            log_q.push_back(buf_q.pop_front());
            log_cyc.push_back(cyc);
            cnt++;
        end
        if (exp_rinc) begin
            buf_q.push_back(fifo_q.pop_front());
            rinc_pulses++;
        end
        cyc++;
        @(negedge rclk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserts reset between edges; buffered words are lost, FIFO contents untouched.
    task automatic reset_async();
        #2 r_rst = 1'b1;
        buf_q.delete();
        cnt = 0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_rinc", rinc, 0);
        chk("rst_word_cnt_w", word_cnt_w, 0);
        @(negedge rclk);
        step();
        r_rst = 1'b0;
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
    endtask

    initial begin
        logic [7:0] words[$];
        r_rst = 1'b1; en = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = 8'h00;
        @(negedge rclk);
        chk("init_m_valid", m_valid, 0);
        chk("init_m_data", m_data, 0);
        chk("init_word_cnt", word_cnt, 0);
        chk("init_rinc", rinc, 0);
        r_rst = 1'b0;

        // Streaming 0x01..0x10
        for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
        en = 1'b1; m_ready = 1'b1; first_rinc_cyc = -1; clear_log();
        steps(20);
        chk("stream_count", log_q.size(), 16);
        for (int i = 0; i < 16 && i < log_q.size(); i++) begin
            chk("stream_data", log_q[i], i + 1);
            chk("stream_gapless", log_cyc[i], log_cyc[0] + i);
        end
        if (log_cyc.size() > 0) chk("stream_latency", log_cyc[0], first_rinc_cyc + 1);
        chk("stream_word_cnt", word_cnt, 16);

        // 17th word wraps the 4-bit counter
        fifo_q.push_back(8'h11);
        steps(3);
        chk("wrap_cnt4", word_cnt_w, 1);
        chk("wrap_cnt16", word_cnt, 17);

        // Backpressure with 0xA0..0xA4
        m_ready = 1'b0; rinc_pulses = 0;
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'hA0 + 8'(i));
        steps(6);
        chk("bp_rinc_pulses", rinc_pulses, 2);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_m_data", m_data, 8'hA0);
        steps(2);
        chk("bp_m_data_hold", m_data, 8'hA0);
        clear_log(); m_ready = 1'b1;
        steps(10);
        chk("bp_count", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk("bp_data", log_q[i], 8'hA0 + i);
            chk("bp_gapless", log_cyc[i], log_cyc[0] + i);
        end

        // Reset while holding two words
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'hC0 + 8'(i));
        steps(4);
        chk("pre_rst_valid", m_valid, 1);
        reset_async();
        clear_log(); m_ready = 1'b1;
        steps(6);
        chk("post_rst_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("post_rst_d0", log_q[0], 8'hC2);
            chk("post_rst_d1", log_q[1], 8'hC3);
        end
        chk("post_rst_word_cnt", word_cnt, 2);

        // Empty FIFO with en toggling
        rinc_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            en = 1'($urandom); m_ready = 1'($urandom);
            step();
        end
        chk("empty_no_rinc", rinc_pulses, 0);

        // en low does not block draining of buffered words
        en = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'h50 + 8'(i));
        steps(3);
        en = 1'b0; m_ready = 1'b1; rinc_pulses = 0; clear_log();
        steps(5);
        chk("en_low_drained", log_q.size(), 2);
        chk("en_low_no_rinc", rinc_pulses, 0);
        chk("en_low_fifo_left", fifo_q.size(), 2);
        en = 1'b1;
        steps(5);

        // Alternating m_ready
        clear_log();
        for (int i = 0; i < 10; i++) begin
            words.push_back(8'($urandom));
            fifo_q.push_back(words[i]);
        end
        for (int i = 0; i < 30; i++) begin
            m_ready = ~cyc[0];
            step();
        end
        chk("alt_count", log_q.size(), 10);
        for (int i = 0; i < 10 && i < log_q.size(); i++) chk("alt_data", log_q[i], words[i]);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                for (int k = $urandom_range(1, 4); k > 0; k--) fifo_q.push_back(8'($urandom));
            en      = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 4) < 3);
            if ($urandom_range(0, 199) == 0) reset_async();
            else step();
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
